// File: rtl/uart_delay_receiver.sv
// 8N1 UART receiver plus 4-byte command parser (header, hi, lo, xor checksum)
// that drives a clamped 16-bit delay register for the phase-delay generator.
module uart_delay_receiver #(
    parameter int          CLKS_PER_BIT  = 3472,
    parameter int          TIMEOUT_CLKS  = 69440,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int          DELAY_MAX     = 10000,
    parameter int          DELAY_DEFAULT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] delay_value,
    output logic        delay_valid,
    output logic        clamped,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        err_frame,
    output logic        err_chk,
    output logic        err_timeout
);

    localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [15:0]      DMAX      = 16'(DELAY_MAX);
    localparam logic [15:0]      DDEF      = 16'(DELAY_DEFAULT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_WAIT_HDR, P_GET_HI, P_GET_LO, P_GET_CHK} p_state_t;

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        rx_state;
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    p_state_t         p_state;
    logic [7:0]       hi_byte;
    logic [7:0]       lo_byte;
    logic [TO_W-1:0]  to_cnt;
    logic [15:0]      req;

    assign req = {hi_byte, lo_byte};

    // Idle-high reset value keeps the receiver from seeing a false start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state      <= RX_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            err_frame     <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            err_frame     <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                RX_STOP: begin
                    // Leave at mid-stop so a back-to-back start bit is not missed.
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte       <= shift;
                            rx_byte_valid <= 1'b1;
                        end else begin
                            err_frame <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state     <= P_WAIT_HDR;
            hi_byte     <= '0;
            lo_byte     <= '0;
            to_cnt      <= '0;
            delay_value <= DDEF;
            delay_valid <= 1'b0;
            clamped     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            delay_valid <= 1'b0;
            clamped     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            if (p_state == P_WAIT_HDR) begin
                to_cnt <= '0;
                if (rx_byte_valid && rx_byte == HEADER) p_state <= P_GET_HI;
            end else if (rx_byte_valid) begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                to_cnt <= '0;
                case (p_state)
                    P_GET_HI: begin
                        hi_byte <= rx_byte;
                        p_state <= P_GET_LO;
                    end
                    P_GET_LO: begin
                        lo_byte <= rx_byte;
                        p_state <= P_GET_CHK;
                    end
                    default: begin
                        if (rx_byte == (HEADER ^ hi_byte ^ lo_byte)) begin
                            delay_value <= (req > DMAX) ? DMAX : req;
                            delay_valid <= 1'b1;
                            clamped     <= (req > DMAX);
                        end else begin
                            err_chk <= 1'b1;
                        end
                        p_state <= P_WAIT_HDR;
                    end
                endcase
            end else if (err_frame) begin
                to_cnt  <= '0;
                p_state <= P_WAIT_HDR;
            end else if (to_cnt == TO_LAST) begin
                to_cnt      <= '0;
                err_timeout <= 1'b1;
                p_state     <= P_WAIT_HDR;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_delay_receiver.sv
// Randomised scoreboard bench: the stimulus side feeds a byte-list command
// model that queues expected events; a monitor pops them as the DUT pulses.
module tb_uart_delay_receiver;

    localparam int CPB  = 16;
    localparam int TO   = 320;
    localparam int DMAX = 10000;

    localparam int EV_BYTE  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_DELAY = 2;
    localparam int EV_CHK   = 3;
    localparam int EV_TMO   = 4;

    typedef struct {
        int kind;
        int val;
        int clamp;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] delay_value;
    logic        delay_valid;
    logic        clamped;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        err_frame;
    logic        err_chk;
    logic        err_timeout;

    ev_t        exp_q[$];
    logic [7:0] pend[$];
    int         n_vec = 0;
    int         n_err = 0;

    uart_delay_receiver #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TO),
        .HEADER       (8'hA5),
        .DELAY_MAX    (DMAX),
        .DELAY_DEFAULT(0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .delay_value  (delay_value),
        .delay_valid  (delay_valid),
        .clamped      (clamped),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .err_frame    (err_frame),
        .err_chk      (err_chk),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int val, input int clamp);
        ev_t e;
        e.kind  = kind;
        e.val   = val;
        e.clamp = clamp;
        exp_q.push_back(e);
    endtask

    // Reference model: collect bytes from a header onward, judge every 4th.
    task automatic model_byte(input logic [7:0] b);
        int r;
        push_ev(EV_BYTE, int'(b), 0);
        if (pend.size() == 0) begin
            if (b == 8'hA5) pend.push_back(b);
        end else begin
            pend.push_back(b);
            if (pend.size() == 4) begin
                r = int'(pend[1]) * 256 + int'(pend[2]);
                if (pend[3] == (pend[0] ^ pend[1] ^ pend[2]))
                    push_ev(EV_DELAY, (r > DMAX) ? DMAX : r, (r > DMAX) ? 1 : 0);
                else
                    push_ev(EV_CHK, 0, 0);
                pend.delete();
            end
        end
    endtask

    task automatic send_raw(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (3 * CPB / 4) @(negedge clk);
            rx = 1'b1;
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b, 1'b1);
        repeat ($urandom_range(0, 40)) @(negedge clk);
    endtask

    task automatic send_bad_stop(input logic [7:0] b);
        push_ev(EV_FRAME, 0, 0);
        pend.delete();
        send_raw(b, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(hi);
        send_byte(lo);
        send_byte(chk);
    endtask

    task automatic send_value(input int v);
        logic [15:0] w;
        w = 16'(v);
        send_frame(w[15:8], w[7:0], 8'hA5 ^ w[15:8] ^ w[7:0]);
    endtask

    task automatic long_idle();
        if (pend.size() != 0) push_ev(EV_TMO, 0, 0);
        pend.delete();
        repeat (TO + 10) @(negedge clk);
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_delay_value"}, int'(delay_value), 0);
        cmp({tag, "_rx_byte"}, int'(rx_byte), 0);
        cmp({tag, "_pulses"}, int'({delay_valid, clamped, rx_byte_valid, err_frame, err_chk, err_timeout}), 0);
    endtask

    task automatic pop_ev(input int kind, input string name, output ev_t e);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            e.kind = -1; e.val = 0; e.clamp = 0;
            $display("FAIL %s: actual unexpected pulse, required no event", name);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_err++;
                $display("FAIL %s: actual event %0d required event %0d", name, kind, e.kind);
            end
        end
    endtask

    // Monitor: every pulse must match the next queued expectation in order.
    initial begin
        ev_t e;
        int  cyc = 0;
        int  last_bv = -10;
        int  exp_delay = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_delay = 0;
                last_bv = -10;
            end else begin
                cyc++;
                if (rx_byte_valid) begin
                    pop_ev(EV_BYTE, "rx_byte_valid", e);
                    if (e.kind == EV_BYTE) cmp("rx_byte", int'(rx_byte), e.val);
                    last_bv = cyc;
                end
                if (err_frame) pop_ev(EV_FRAME, "err_frame", e);
                if (delay_valid) begin
                    pop_ev(EV_DELAY, "delay_valid", e);
                    if (e.kind == EV_DELAY) begin
                        cmp("delay_value", int'(delay_value), e.val);
                        cmp("clamped", int'(clamped), e.clamp);
                        exp_delay = e.val;
                    end
                    cmp("delay_latency", cyc - last_bv, 1);
                end
                if (err_chk) begin
                    pop_ev(EV_CHK, "err_chk", e);
                    cmp("err_chk_latency", cyc - last_bv, 1);
                end
                if (clamped && !delay_valid) cmp("clamped_alone", 1, 0);
                if (err_timeout) pop_ev(EV_TMO, "err_timeout", e);
                if (rx_byte_valid || err_frame || delay_valid || err_chk || err_timeout)
                    cmp("delay_hold", int'(delay_value), exp_delay);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: actual cycle budget exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int v;
        logic [7:0] c;

        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(8'h0F, 8'hA0, 8'h0A);
        send_frame(8'h3A, 8'h98, 8'h07);
        send_frame(8'h27, 8'h10, 8'h92);
        send_frame(8'h0F, 8'hA0, 8'h0A);
        send_frame(8'h0F, 8'hA0, 8'h0B);
        send_frame(8'h13, 8'h88, 8'h3E);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h00, 8'h64, 8'hC1);
        glitch(4);
        glitch(1);
        send_frame(8'hA5, 8'h00, 8'h00);
        send_byte(8'hA5);
        send_byte(8'h0F);
        long_idle();
        send_frame(8'h00, 8'h64, 8'hC1);
        send_byte(8'hA5);
        send_byte(8'h12);
        send_bad_stop(8'h34);
        send_frame(8'h00, 8'h64, 8'hC1);

        // Reset while the parser is waiting for the low byte.
        send_byte(8'hA5);
        send_byte(8'h0F);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pend.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h13, 8'h88, 8'h3E);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12000) : $urandom_range(0, 65535);
                send_value(v);
            end else if (op == 5) begin
                v = $urandom_range(0, 65535);
                c = 8'hA5 ^ v[15:8] ^ v[7:0];
                c = c ^ (8'h01 << $urandom_range(0, 7));
                send_frame(v[15:8], v[7:0], c);
            end else if (op == 6) begin
                send_byte(8'($urandom_range(0, 255)));
            end else if (op == 7) begin
                glitch($urandom_range(1, CPB / 2 - 3));
            end else if (op == 8) begin
                send_byte(8'hA5);
                send_bad_stop(8'($urandom_range(0, 255)));
            end else begin
                send_byte(8'hA5);
                send_byte(8'($urandom_range(0, 255)));
                long_idle();
            end
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        cmp("queue_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_delay_receiver.md
Name: uart_delay_receiver

Overview:
- Upstream feeder of the three-channel 40 kHz phase-delayed transducer generator.
- Receives 8N1 serial frames from the host PC and validates a 4-byte delay command.
- Drives the generator's 16-bit delay_value input. The register updates atomically and holds its value between commands.
- Runs on the same 400 MHz clock as the generator.

Parameters:
CLKS_PER_BIT, 3472, clock cycles per UART bit (400 MHz / 115200 baud)
TIMEOUT_CLKS, 69440, inter-byte timeout inside a frame (about 20 bit times)
HEADER, 8'hA5, frame start byte
DELAY_MAX, 10000, upper clamp for delay_value (one 40 kHz period in clocks)
DELAY_DEFAULT, 0, delay_value after reset

Ports:
clk  input  1  system clock, 400 MHz
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx  input  1  asynchronous UART line, idle high
delay_value  output  16  validated delay in clocks, to the generator
delay_valid  output  1  one-cycle pulse when delay_value is updated
clamped  output  1  one-cycle pulse, coincident with delay_valid, when the request exceeded DELAY_MAX
rx_byte  output  8  last received byte (debug)
rx_byte_valid  output  1  one-cycle pulse per correctly framed byte
err_frame  output  1  one-cycle pulse: stop bit sampled low
err_chk  output  1  one-cycle pulse: checksum mismatch
err_timeout  output  1  one-cycle pulse: frame abandoned on timeout

Behaviour:
- Reset (reset low, asynchronous) sets:
  - delay_value = DELAY_DEFAULT, rx_byte = 0.
  - All pulse outputs = 0.
  - Both FSMs to idle, all counters to 0.
  - The synchronizer flops to 1.
- Reset mid-frame discards the partial frame. delay_value returns to DELAY_DEFAULT.
- rx is synchronized through 2 flops before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge (low sample).
  - START: wait CLKS_PER_BIT/2 (integer), then re-sample. Low -> DATA. High -> IDLE as a glitch, with no output.
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT.
    - High: rx_byte loaded and rx_byte_valid pulses on the next cycle.
    - Low: err_frame pulses and no byte is emitted.
  - After STOP, return to IDLE (do not wait for the full stop-bit end).
- Parser FSM states: WAIT_HDR, GET_HI, GET_LO, GET_CHK. It advances only on rx_byte_valid.
  - WAIT_HDR: byte == HEADER -> GET_HI. Any other byte is silently ignored.
  - GET_HI: latch the high byte. GET_LO: latch the low byte.
  - GET_CHK: the expected checksum is HEADER ^ hi ^ lo.
    - Match: on the next edge, delay_value <= min({hi,lo}, DELAY_MAX) and delay_valid pulses in the same cycle. clamped pulses if {hi,lo} > DELAY_MAX.
    - Mismatch: err_chk pulses and delay_value is unchanged.
    - Either way -> WAIT_HDR.
- Latency: delay_value changes exactly 1 cycle after the rx_byte_valid of the checksum byte.
- All 16 bits update on one edge; no intermediate value is ever visible.
- Timeout:
  - In GET_HI/GET_LO/GET_CHK, a counter increments every cycle and clears on each rx_byte_valid.
  - At TIMEOUT_CLKS: err_timeout pulses, parser -> WAIT_HDR, partial data is discarded.
  - The counter is held at 0 in WAIT_HDR.
- err_frame while the parser is in GET_*: the parser aborts to WAIT_HDR. err_timeout is not also raised.
- Simultaneous events: if the timeout expiry and rx_byte_valid occur in the same cycle, the byte wins and the counter clears.
- A header byte received in GET_* is treated as data, not as a resync.
- Counter widths: bit counter ≥ clog2(CLKS_PER_BIT+1) bits; timeout counter ≥ clog2(TIMEOUT_CLKS+1) bits. No wrap-around is permitted before terminal count.

Test Plan:
- Valid frame A5 0F A0 0A -> delay_value = 4000 one cycle after the last rx_byte_valid; delay_valid = 1 for exactly 1 cycle; clamped = 0; no error pulses.
- Over-range frame A5 3A 98 07 (15000) -> delay_value = 10000, delay_valid and clamped pulse together. Frame A5 27 10 92 (10000) -> clamped stays 0.
- Bad checksum A5 0F A0 0B after a prior value of 4000 -> err_chk pulses once, delay_valid stays 0, delay_value stays 4000. The next good frame A5 13 88 3E -> delay_value = 5000.
- Resync and noise:
  - Bytes 00 FF then A5 00 64 C1 -> first two ignored with no errors; delay_value = 100.
  - A rx low glitch shorter than CLKS_PER_BIT/2 in IDLE -> no rx_byte_valid, no err_frame.
- Faults:
  - A5 0F, then idle for TIMEOUT_CLKS+10 -> err_timeout pulses once. Then A5 00 64 C1 -> delay_value = 100.
  - A byte with stop bit forced low mid-frame -> err_frame pulses, parser back to WAIT_HDR.
- Reset: assert reset low during GET_LO of a frame -> all outputs return to their reset values immediately. Release reset, send a complete frame -> it is accepted normally.
